bisqrt_jk_multi: RTL and testbench

Multi-channel, parametrised successor to the single-lane JK-trace unary square-root approximator.
- Each of CH lanes takes a unipolar bitstream and emits a bitstream with 1s inserted after input 1s.
- The insertion is driven by a trace counter of configurable depth, generalising the single JK flip-flop.
- Each lane also counts its output 1s over a fixed window of 2^CNT_W enabled cycles and presents a binary result with a one-cycle valid strobe, so downstream binary logic can sample it without a separate counter.

---
 rtl/bisqrt_pkg.sv | 24 ++
 rtl/bisqrt_jk_multi_if.sv | 24 ++
 rtl/bisqrt_jk_lane.sv | 56 +++++
 rtl/bisqrt_jk_multi.sv | 74 +++++++
 tb/tb_bisqrt_jk_multi.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bisqrt_pkg.sv
// Shared width helpers for the multi-lane JK-trace square-root approximator.
package bisqrt_pkg;

    // Ceiling log2, usable in parameter context; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Trace counter width: must hold 0..depth, never narrower than one bit.
    function automatic int trace_w(input int depth);
        return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
    endfunction

    // Window count width: one extra bit so the all-ones window (2^cnt_w) fits.
    function automatic int result_w(input int cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/bisqrt_jk_multi_if.sv
// Control, bitstream and result bundle of the multi-lane approximator.
interface bisqrt_jk_multi_if
    import bisqrt_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic                           en;
    logic                           clr;
    logic [CH-1:0]                  in;
    logic [CH-1:0]                  out;
    logic [CH*result_w(CNT_W)-1:0]  result;
    logic                           result_valid;

    modport master (
        output en, clr, in,
        input  out, result, result_valid
    );

    modport slave (
        input  en, clr, in,
        output out, result, result_valid
    );
endinterface

// File: rtl/bisqrt_jk_lane.sv
// One lane: trace counter that stretches each input 1 by DEPTH extra 1s,
// plus the window accumulator of output 1s.
module bisqrt_jk_lane
    import bisqrt_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        upd,
    input  logic                        last_cycle,
    input  logic                        in,
    output logic                        out,
    output logic [result_w(CNT_W)-1:0]  sum
);
    localparam int TW = trace_w(DEPTH);
    localparam int RW = result_w(CNT_W);

    logic [TW-1:0] t;
    logic [RW-1:0] acc;

    // Output is live regardless of en: a pending trace or the input itself.
    assign out = (t != '0) | in;

    // Count including this cycle's output, so the top can latch it on the last window cycle.
    assign sum = acc + RW'(out);

    // Trace: count down while active, otherwise re-arm on an input 1.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (clr) begin
            t <= '0;
        end else if (upd) begin
            if (t != '0) begin
                t <= t - TW'(1);
            end else if (in) begin
                t <= TW'(DEPTH);
            end
        end
    end

    // Accumulator: add output 1s, restart from zero after the last window cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (upd) begin
            acc <= last_cycle ? '0 : sum;
        end
    end
endmodule

// File: rtl/bisqrt_jk_multi.sv
// Multi-lane JK-trace unary square-root approximator with windowed binary readout.
module bisqrt_jk_multi
    import bisqrt_pkg::*;
#(
    parameter int CH    = 4,
    parameter int DEPTH = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    bisqrt_jk_multi_if.slave  bus
);
    localparam int RW = result_w(CNT_W);

    logic [CNT_W-1:0] wcnt;
    logic             last_cycle;
    logic             upd;
    logic [CH-1:0]    out_vec;
    logic [CH*RW-1:0] sums;
    logic [CH*RW-1:0] result_q;
    logic             result_valid_q;

    assign last_cycle = &wcnt;
    assign upd        = bus.en & ~bus.clr;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        bisqrt_jk_lane #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .clr        (bus.clr),
            .upd        (upd),
            .last_cycle (last_cycle),
            .in         (bus.in[c]),
            .out        (out_vec[c]),
            .sum        (sums[c*RW +: RW])
        );
    end

    // Shared window position; wraps naturally after the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (bus.clr) begin
            wcnt <= '0;
        end else if (bus.en) begin
            wcnt <= wcnt + CNT_W'(1);
        end
    end

    // Strobe for exactly the cycle after a completed window; clr suppresses it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= upd & last_cycle;
        end
    end

    // Result register: capture all lane sums at window end, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else if (upd & last_cycle) begin
            result_q <= sums;
        end
    end

    assign bus.out          = out_vec;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_bisqrt_jk_multi.sv
// Bench: two instances (DEPTH=1 and DEPTH=3, CNT_W=4) driven identically and
// compared cycle by cycle against a behavioural model of the window counts.
module tb_bisqrt_jk_multi;
    localparam int CH    = 4;
    localparam int CNT_W = 4;
    localparam int WIN   = 1 << CNT_W;
    localparam int RW    = CNT_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bisqrt_jk_multi_if #(.CH(CH), .CNT_W(CNT_W)) bus1 ();
    bisqrt_jk_multi_if #(.CH(CH), .CNT_W(CNT_W)) bus3 ();

    bisqrt_jk_multi #(.CH(CH), .DEPTH(1), .CNT_W(CNT_W)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    bisqrt_jk_multi #(.CH(CH), .DEPTH(3), .CNT_W(CNT_W)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 models DEPTH=1, index 1 models DEPTH=3.
    int m_t   [2][CH];
    int m_acc [2][CH];
    int m_res [2][CH];
    int m_wcnt;
    bit m_rv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int depth_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [CH-1:0] exp_out(input int d, input logic [CH-1:0] x);
        logic [CH-1:0] r;
        for (int l = 0; l < CH; l++) begin
            r[l] = (m_t[d][l] != 0) || x[l];
        end
        return r;
    endfunction

    function automatic logic [CH*RW-1:0] exp_res(input int d);
        logic [CH*RW-1:0] r;
        for (int l = 0; l < CH; l++) begin
            r[l*RW +: RW] = RW'(m_res[d][l]);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < CH; l++) begin
                m_t[d][l]   = 0;
                m_acc[d][l] = 0;
                m_res[d][l] = 0;
            end
        end
        m_wcnt = 0;
        m_rv   = 1'b0;
    endtask

    task automatic model_update(input bit e, input bit c, input logic [CH-1:0] x);
        logic [CH-1:0] o [2];
        o[0] = exp_out(0, x);
        o[1] = exp_out(1, x);
        if (c) begin
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < CH; l++) begin
                    m_t[d][l]   = 0;
                    m_acc[d][l] = 0;
                end
            end
            m_wcnt = 0;
            m_rv   = 1'b0;
        end else if (e) begin
            for (int d = 0; d < 2; d++) begin
                for (int l = 0; l < CH; l++) begin
                    if (m_wcnt == WIN - 1) begin
                        m_res[d][l] = m_acc[d][l] + int'(o[d][l]);
                        m_acc[d][l] = 0;
                    end else begin
                        m_acc[d][l] += int'(o[d][l]);
                    end
                    if (m_t[d][l] != 0)  m_t[d][l]--;
                    else if (x[l])       m_t[d][l] = depth_of(d);
                end
            end
            m_rv   = (m_wcnt == WIN - 1);
            m_wcnt = (m_wcnt + 1) % WIN;
        end else begin
            m_rv = 1'b0;
        end
    endtask

    task automatic drive(input bit e, input bit c, input logic [CH-1:0] x);
        bus1.en = e;  bus1.clr = c;  bus1.in = x;
        bus3.en = e;  bus3.clr = c;  bus3.in = x;
    endtask

    // One clock: drive after the falling edge, check out mid-low phase,
    // advance the model at the rising edge, check registered outputs 1 ns later.
    task automatic step(input bit e, input bit c, input logic [CH-1:0] x);
        drive(e, c, x);
        #1;
        check("out_d1", 32'(bus1.out), 32'(exp_out(0, x)));
        check("out_d3", 32'(bus3.out), 32'(exp_out(1, x)));
        @(posedge clk);
        model_update(e, c, x);
        #1;
        check("valid_d1", 32'(bus1.result_valid), 32'(m_rv));
        check("valid_d3", 32'(bus3.result_valid), 32'(m_rv));
        check("result_d1", 32'(bus1.result), 32'(exp_res(0)));
        check("result_d3", 32'(bus3.result), 32'(exp_res(1)));
        @(negedge clk);
    endtask

    initial begin
        logic [CH-1:0] x;
        int k;

        // Reset state: outputs zero, out passes in straight through.
        model_reset();
        drive(1'b1, 1'b0, 4'b1010);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus1.result_valid), 32'd0);
        check("rst_result", 32'(bus1.result), 32'd0);
        check("rst_out_d1", 32'(bus1.out), 32'h0000_000a);
        check("rst_out_d3", 32'(bus3.out), 32'h0000_000a);
        rst = 1'b0;

        // Lane 0 all zero, lane 1 1000, lane 2 1010, lane 3 all one; three windows.
        for (int i = 0; i < 3 * WIN; i++) begin
            x = {1'b1, (i % 2 == 0), (i % 4 == 0), 1'b0};
            step(1'b1, 1'b0, x);
        end
        check("dir_lanes_d1", 32'(bus1.result), {12'd0, 5'd16, 5'd16, 5'd8, 5'd0});
        check("dir_lanes_d3", 32'(bus3.result), {12'd0, 5'd16, 5'd16, 5'd16, 5'd0});

        // Lane 0 pattern 10000000, other lanes random.
        step(1'b1, 1'b1, 4'b0000);
        for (int i = 0; i < 2 * WIN; i++) begin
            x = 4'($urandom);
            x[0] = (i % 8 == 0);
            step(1'b1, 1'b0, x);
        end
        check("sparse_d1", 32'(bus1.result[RW-1:0]), 32'd4);
        check("sparse_d3", 32'(bus3.result[RW-1:0]), 32'd8);

        // en toggling; lane 1 carries 1000 counted over enabled cycles only.
        step(1'b1, 1'b1, 4'b0000);
        k = 0;
        for (int i = 0; i < 4 * WIN; i++) begin
            x = 4'($urandom);
            if (i % 2 == 0) begin
                x[1] = (k % 4 == 0);
                k++;
            end
            step(i % 2 == 0, 1'b0, x);
        end
        check("toggle_en_d1", 32'(bus1.result[RW +: RW]), 32'd8);

        // clr mid-window at wcnt=10, then a full fresh window.
        for (int i = 0; i < 2 * WIN && m_wcnt != 10; i++) begin
            step(1'b1, 1'b0, 4'($urandom));
        end
        check("reach_wcnt10", 32'(m_wcnt), 32'd10);
        step(1'($urandom), 1'b1, 4'($urandom));
        for (int i = 0; i < WIN + 4; i++) begin
            step(1'b1, 1'b0, 4'($urandom));
        end

        // clr on the last window cycle: strobe and result update suppressed.
        for (int i = 0; i < 2 * WIN && m_wcnt != WIN - 1; i++) begin
            step(1'b1, 1'b0, 4'($urandom));
        end
        step(1'b1, 1'b1, 4'($urandom));
        check("clr_last_no_strobe", 32'(bus1.result_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 4'($urandom));
        end

        // Random en, occasional clr, random inputs.
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, ($urandom % 32) == 0, 4'($urandom));
        end

        // Asynchronous reset between edges, mid-window.
        for (int i = 0; i < WIN + 7; i++) begin
            step(1'b1, 1'b0, 4'b1111);
        end
        drive(1'b1, 1'b0, 4'b0101);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus1.result_valid), 32'd0);
        check("arst_result_d1", 32'(bus1.result), 32'd0);
        check("arst_result_d3", 32'(bus3.result), 32'd0);
        check("arst_out", 32'(bus3.out), 32'h0000_0005);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIN + 2; i++) begin
            step(1'b1, 1'b0, 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
